sine_freq_ctrl: RTL and testbench
=================================

# sine_freq_ctrl

Front-panel frequency controller for the sine PWM generator. It takes three raw push-buttons (up, down, run), synchronises and debounces them, and keeps a saturating frequency-step index. The index is converted to the 12-bit intervals-per-step value N and a run/stop level, which drive the generator's `Nentrada` and `opr` inputs. Output sine frequency is f_clk / (2^R · 36 · N), so a larger N gives a lower frequency.

## Interface
- `DEB_CYCLES`, 50000: consecutive stable cycles required to accept a button level change (≥2).
- `HOLD_CYCLES`, 25000000: cycles a lone up/down button must be held after its first step before auto-repeat begins.
- `REP_CYCLES`, 5000000: auto-repeat period while held.
- `N_MIN`, 1: N at index 0.
- `N_STEP`, 64: N increment per index.
- `IDX_MAX`, 63: highest index. Elaboration error if N_MIN + IDX_MAX·N_STEP > 4095.
- `RESET_IDX`, 15: index after reset (≤ IDX_MAX).
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `btn_up`  in  1: raw, asynchronous, bouncing, active-high. Decrements the index (raises frequency).
- `btn_down`  in  1: raw, active-high. Increments the index (lowers frequency).
- `btn_run`  in  1: raw, active-high. Toggles `opr`.
- `n_out`  out  12: N to the generator; registered.
- `opr`  out  1: run enable to the generator; registered.
- `idx_out`  out  6: current index, for display.
- `n_upd`  out  1: one-cycle pulse marking that `n_out` changed.

## Operation
- Reset values (async on `rst_n` low):
  - idx = RESET_IDX; n_out = N_MIN + RESET_IDX·N_STEP.
  - opr = 0; n_upd = 0.
  - All synchroniser and debounced levels 0; all counters 0.
- Per button: 2-flop synchroniser, then debouncer.
  - Debounced level flips when the synchronised input differs from it for DEB_CYCLES consecutive cycles.
  - Any cycle of agreement clears the debounce counter.
- Step events are taken on debounced rising edges only.
  - up: idx ← idx−1. down: idx ← idx+1.
  - run: opr ← ~opr. `run` is independent of up/down.
- Saturation: up at idx 0, or down at IDX_MAX, produces no change and no `n_upd`.
- Simultaneous: if both debounced up and down are high, no up/down steps occur and the repeat logic is held idle. Releasing one of them does not create a step.
- Auto-repeat state machine, evaluated only when exactly one of up/down is debounced-high:
  - IDLE → (rising edge: step) HOLD.
  - HOLD counts HOLD_CYCLES → step, REPEAT.
  - REPEAT steps every REP_CYCLES.
  - Debounced release, or both buttons high → IDLE with counters cleared.
- Width rule: n_out = N_MIN + idx·N_STEP, computed in ≥13 bits, then truncated to 12 bits. The elaboration check guarantees no overflow.
- Reset mid-hold or mid-debounce abandons the pending event. Nothing is stepped on release of reset, even if a button is held. A step requires a fresh debounced rising edge, because the debounced level starts at 0 and must first rise.

## Timing
- Raw input stable from edge 0:
  - Synchronised at edge 2.
  - Debounced level changes at edge 2+DEB_CYCLES.
  - idx, n_out and opr update at edge 3+DEB_CYCLES.
- `n_upd` is high for exactly the one cycle following the edge at which `n_out` changed.
- Auto-repeat:
  - First repeat step is HOLD_CYCLES cycles after the initial step.
  - Later steps follow every REP_CYCLES cycles.
  - Each step updates idx, n_out and `n_upd` with the same edge relationship as above.
- Bounce shorter than DEB_CYCLES produces no output activity.
- Outputs change only on `clk` edges or asynchronously on reset.

## Test plan
Bench parameters: DEB_CYCLES=4, HOLD_CYCLES=20, REP_CYCLES=8, N_MIN=1, N_STEP=64, IDX_MAX=63, RESET_IDX=15.

- Reset: assert `rst_n` low mid-run → n_out=961, idx_out=15, opr=0, n_upd=0 immediately. Outputs stay unchanged after release.
- Bouncy down press (toggle every 2 cycles for 12 cycles, then held 10 cycles) → exactly one step: idx=16, n_out=1025, one `n_upd` pulse, 7 cycles (3+DEB_CYCLES) after the level settles.
- Hold up for 60 cycles after debounce → steps at t0, t0+20, t0+28, t0+36, t0+44, t0+52. Final idx=9, n_out=577.
- Saturation: start at idx 1, press up twice → idx 0, n_out=1. Second press gives no `n_upd`. Symmetric check: down at idx 63 stays at n_out=4033.
- Both buttons pressed together and held for 40 cycles, then up released → idx unchanged, no `n_upd`.
- Run button pressed twice → opr goes 0→1→0. n_out is unaffected and `n_upd` never pulses.

Source files
------------

// File: rtl/sine_freq_ctrl.sv
// sine_freq_ctrl
//   Front-panel frequency controller for the sine PWM generator. Three raw
//   push-buttons are synchronised and debounced. The up/down buttons move a
//   saturating frequency-step index, with hold-to-repeat. The run button
//   toggles the run enable. The index is mapped to the generator's
//   intervals-per-step value N = N_MIN + idx*N_STEP. A larger N gives a
//   lower output frequency.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   btn_up    in   raw button; a step decrements idx (raises frequency)
//   btn_down  in   raw button; a step increments idx (lowers frequency)
//   btn_run   in   raw button; a press toggles opr
//   n_out     out  [11:0] N for the generator, registered
//   opr       out  run enable for the generator, registered
//   idx_out   out  [5:0] current index, for display
//   n_upd     out  one-cycle pulse in the cycle after n_out changed

// Per-button lane: 2-flop synchroniser followed by a debouncer. The
// debounced level flips only after the synchronised input has disagreed
// with it for DEB_CYCLES consecutive cycles. Any cycle of agreement
// restarts the count.
module sine_freq_ctrl_btn #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // This is the DEB_CYCLES-th disagreeing cycle.
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module sine_freq_ctrl #(
    parameter int DEB_CYCLES  = 50000,
    parameter int HOLD_CYCLES = 25000000,
    parameter int REP_CYCLES  = 5000000,
    parameter int N_MIN       = 1,
    parameter int N_STEP      = 64,
    parameter int IDX_MAX     = 63,
    parameter int RESET_IDX   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_run,
    output logic [11:0] n_out,
    output logic        opr,
    output logic [5:0]  idx_out,
    output logic        n_upd
);
    // Parameter sanity checks, resolved at elaboration.
    if (N_MIN + IDX_MAX * N_STEP > 4095) begin : g_bad_range
        $error("sine_freq_ctrl: N_MIN + IDX_MAX*N_STEP exceeds 4095");
    end
    if (IDX_MAX > 63 || IDX_MAX < 1) begin : g_bad_idx
        $error("sine_freq_ctrl: IDX_MAX must be in 1..63");
    end
    if (RESET_IDX > IDX_MAX || RESET_IDX < 0) begin : g_bad_rst
        $error("sine_freq_ctrl: RESET_IDX must be in 0..IDX_MAX");
    end
    if (DEB_CYCLES < 2 || HOLD_CYCLES < 1 || REP_CYCLES < 1) begin : g_bad_cyc
        $error("sine_freq_ctrl: cycle parameters out of range");
    end

    localparam int NB  = 3;
    localparam int UP  = 0;
    localparam int DN  = 1;
    localparam int RUN = 2;

    localparam logic [5:0]  IDX_LAST = 6'(IDX_MAX);
    localparam logic [5:0]  IDX_RST  = 6'(RESET_IDX);
    localparam logic [11:0] N_RST    = 12'(N_MIN + RESET_IDX * N_STEP);

    localparam int RC_MAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
    localparam int RCW    = $clog2(RC_MAX + 1);
    localparam logic [RCW-1:0] HOLD_LAST = RCW'(HOLD_CYCLES - 1);
    localparam logic [RCW-1:0] REP_LAST  = RCW'(REP_CYCLES - 1);

    // ------------------------------------------------------------------
    // Button lanes
    // ------------------------------------------------------------------
    logic [NB-1:0] raw_btn;
    logic [NB-1:0] deb;
    logic [NB-1:0] deb_q;
    logic [NB-1:0] rise;

    assign raw_btn = {btn_run, btn_down, btn_up};

    for (genvar i = 0; i < NB; i++) begin : g_lane
        sine_freq_ctrl_btn #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_btn[i]),
            .level(deb[i])
        );
    end

    // The debounced levels reset to 0, so a button held through reset
    // still has to produce a fresh rising edge before anything steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) deb_q <= '0;
        else        deb_q <= deb;
    end

    assign rise = deb & ~deb_q;

    // Auto-repeat only runs while exactly one of up/down is held. Both
    // held, or neither held, parks it in IDLE with the counter cleared.
    // Releasing one of a pair is not a rising edge, so it cannot step.
    logic one_btn;
    assign one_btn = deb[UP] ^ deb[DN];

    // ------------------------------------------------------------------
    // Auto-repeat FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT
    } rep_state_t;

    rep_state_t     state, state_nxt;
    logic [RCW-1:0] rcnt, rcnt_nxt;
    logic           step_req;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        if (!one_btn) begin
            state_nxt = S_IDLE;
            rcnt_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rcnt_nxt = '0;
                    if (rise[UP] || rise[DN]) state_nxt = S_HOLD;
                end
                S_HOLD: begin
                    if (rcnt == HOLD_LAST) begin
                        state_nxt = S_REPEAT;
                        rcnt_nxt  = '0;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (rcnt == REP_LAST) rcnt_nxt = '0;
                    else                  rcnt_nxt = rcnt + 1'b1;
                end
                default: begin
                    state_nxt = S_IDLE;
                    rcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Output logic: a step is due on the first rising edge, at the end of
    // the hold interval, and at the end of every repeat interval.
    always_comb begin
        step_req = 1'b0;
        if (one_btn) begin
            case (state)
                S_IDLE:   step_req = rise[UP] | rise[DN];
                S_HOLD:   step_req = (rcnt == HOLD_LAST);
                S_REPEAT: step_req = (rcnt == REP_LAST);
                default:  step_req = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Index, N and run enable
    // ------------------------------------------------------------------
    logic [5:0]  idx, idx_nxt;
    logic [12:0] n_wide;
    logic        idx_chg;

    // Direction comes from whichever button is held. The saturation
    // limits swallow the step entirely, so no n_upd is produced there.
    always_comb begin
        idx_nxt = idx;
        if (step_req && deb[UP] && idx != 6'd0)
            idx_nxt = idx - 6'd1;
        else if (step_req && deb[DN] && idx != IDX_LAST)
            idx_nxt = idx + 6'd1;
    end

    assign idx_chg = (idx_nxt != idx);

    // N is formed from the next index, so idx and n_out move on the same
    // edge. 13 bits hold the full sum; the range check above keeps it in
    // 12 bits, so the truncation drops nothing.
    assign n_wide = 13'(N_MIN) + 13'(idx_nxt) * 13'(N_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= IDX_RST;
            n_out <= N_RST;
            n_upd <= 1'b0;
            opr   <= 1'b0;
        end else begin
            idx   <= idx_nxt;
            n_out <= n_wide[11:0];
            n_upd <= idx_chg;
            opr   <= opr ^ rise[RUN];
        end
    end

    assign idx_out = idx;
endmodule

// File: tb/tb_sine_freq_ctrl.sv
module tb_sine_freq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_run = 1'b0;
    logic [11:0] n_out;
    logic        opr;
    logic [5:0]  idx_out;
    logic        n_upd;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulses = 0;
    int plog[$];

    sine_freq_ctrl #(
        .DEB_CYCLES (4),
        .HOLD_CYCLES(20),
        .REP_CYCLES (8),
        .N_MIN      (1),
        .N_STEP     (64),
        .IDX_MAX    (63),
        .RESET_IDX  (15)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .btn_run (btn_run),
        .n_out   (n_out),
        .opr     (opr),
        .idx_out (idx_out),
        .n_upd   (n_upd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (n_upd === 1'b1) begin
                pulses++;
                plog.push_back(cyc);
            end
        end
    endtask

    task automatic clr();
        cyc = 0;
        pulses = 0;
        plog.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        clr();
    endtask

    int exp_p[6] = '{7, 27, 35, 43, 51, 59};

    initial begin
        // ---- reset values ----
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_idx", idx_out, 15);
        chk("rst_n_out", n_out, 961);
        chk("rst_opr", opr, 0);
        chk("rst_n_upd", n_upd, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        clr();
        chk("post_rst_n_out", n_out, 961);

        // ---- bouncy down press: 2-cycle bounces, then a steady hold ----
        for (int i = 0; i < 12; i++) begin
            btn_down = ((i % 4) < 2);
            tick(1);
        end
        btn_down = 1'b1;
        tick(6);
        chk("bounce_idx_before", idx_out, 15);
        tick(1);
        chk("bounce_idx", idx_out, 16);
        chk("bounce_n_out", n_out, 1025);
        tick(3);
        btn_down = 1'b0;
        tick(20);
        chk("bounce_pulses", pulses, 1);
        chk("bounce_pulse_cyc", (plog.size() > 0) ? plog[0] : -1, 19);

        // ---- run button: 0 -> 1 -> 0, N untouched ----
        clr();
        btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(10);
        chk("run1_opr", opr, 1);
        btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(10);
        chk("run2_opr", opr, 0);
        chk("run_n_out", n_out, 1025);
        chk("run_pulses", pulses, 0);
        btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(10);
        chk("run3_opr", opr, 1);

        // ---- reset mid-debounce ----
        btn_down = 1'b1;
        tick(3);
        rst_n = 1'b0;
        btn_down = 1'b0;
        #1;
        chk("midrst_n_out", n_out, 961);
        chk("midrst_idx", idx_out, 15);
        chk("midrst_opr", opr, 0);
        chk("midrst_n_upd", n_upd, 0);
        tick(2);
        rst_n = 1'b1;
        clr();
        tick(20);
        chk("after_rst_idx", idx_out, 15);
        chk("after_rst_n_out", n_out, 961);
        chk("after_rst_pulses", pulses, 0);

        // ---- hold up: initial step, hold interval, then repeats ----
        clr();
        btn_up = 1'b1;
        tick(56);
        btn_up = 1'b0;
        tick(14);
        chk("hold_pulses", pulses, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("hold_pulse%0d", i), (i < plog.size()) ? plog[i] : -1, exp_p[i]);
        chk("hold_idx", idx_out, 9);
        chk("hold_n_out", n_out, 577);

        // ---- both buttons together, then up released ----
        clr();
        btn_up = 1'b1;
        btn_down = 1'b1;
        tick(40);
        btn_up = 1'b0;
        tick(20);
        btn_down = 1'b0;
        tick(15);
        chk("both_pulses", pulses, 0);
        chk("both_idx", idx_out, 9);
        chk("both_n_out", n_out, 577);

        // ---- saturation at idx 0 ----
        do_reset();
        btn_up = 1'b1;
        tick(120);
        btn_up = 1'b0;
        tick(20);
        chk("sat_lo_walk_pulses", pulses, 14);
        chk("sat_lo_start_idx", idx_out, 1);
        chk("sat_lo_start_n", n_out, 65);
        clr();
        btn_up = 1'b1; tick(8); btn_up = 1'b0; tick(10);
        chk("sat_lo_p1_pulses", pulses, 1);
        chk("sat_lo_p1_idx", idx_out, 0);
        chk("sat_lo_p1_n", n_out, 1);
        clr();
        btn_up = 1'b1; tick(8); btn_up = 1'b0; tick(10);
        chk("sat_lo_p2_pulses", pulses, 0);
        chk("sat_lo_p2_n", n_out, 1);

        // ---- saturation at idx 63 ----
        clr();
        btn_down = 1'b1;
        tick(512);
        btn_down = 1'b0;
        tick(20);
        chk("sat_hi_walk_pulses", pulses, 63);
        chk("sat_hi_idx", idx_out, 63);
        chk("sat_hi_n", n_out, 4033);
        clr();
        btn_down = 1'b1; tick(8); btn_down = 1'b0; tick(10);
        chk("sat_hi_p_pulses", pulses, 0);
        chk("sat_hi_p_n", n_out, 4033);
        chk("sat_hi_p_idx", idx_out, 63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
